// File: rtl/reset_release_sequencer.sv
// Reset release sequencer: asserts every downstream reset asynchronously, then
// releases them one stage at a time, waiting for each stage's acknowledge.
module reset_release_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_OUTS    = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                async_reset,
  input  logic                ext_reset_req,
  input  logic [NUM_OUTS-1:0] rst_ack,
  output logic [NUM_OUTS-1:0] rst_out,
  output logic                all_released,
  output logic                timeout_err
);

  localparam int CNT_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int TCNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int IDX_W  = (NUM_OUTS > 1) ? $clog2(NUM_OUTS) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(ACK_TIMEOUT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_OUTS - 1);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_HOLD  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync_rst;

  state_t                 r_state, w_state_nxt;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
  logic [TCNT_W-1:0]      r_tcnt, w_tcnt_nxt;
  logic [IDX_W-1:0]       r_idx, w_idx_nxt;
  logic [NUM_OUTS-1:0]    r_rst_out, w_rst_nxt;
  logic                   r_all, w_all_nxt;
  logic                   r_terr, w_terr_nxt;
  logic                   w_advance;

  // Deassertion synchronizer: set asynchronously, drains to 0 one flop per edge.
  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b0};
    end
  end

  assign w_sync_rst = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      r_state   <= ST_RESET;
      r_cnt     <= '0;
      r_tcnt    <= '0;
      r_idx     <= '0;
      r_rst_out <= '1;
      r_all     <= 1'b0;
      r_terr    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_tcnt    <= w_tcnt_nxt;
      r_idx     <= w_idx_nxt;
      r_rst_out <= w_rst_nxt;
      r_all     <= w_all_nxt;
      r_terr    <= w_terr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_tcnt_nxt  = r_tcnt;
    w_idx_nxt   = r_idx;
    w_rst_nxt   = r_rst_out;
    w_all_nxt   = r_all;
    w_terr_nxt  = r_terr;
    w_advance   = 1'b0;

    // Soft reset re-asserts everything but keeps the sticky timeout flag.
    if ((r_state != ST_RESET) && ext_reset_req) begin
      w_state_nxt = ST_HOLD;
      w_cnt_nxt   = '0;
      w_tcnt_nxt  = '0;
      w_idx_nxt   = '0;
      w_rst_nxt   = '1;
      w_all_nxt   = 1'b0;
    end else begin
      case (r_state)
        ST_RESET: begin
          if (!w_sync_rst) begin
            w_state_nxt = ST_HOLD;
            w_cnt_nxt   = '0;
          end
        end
        ST_HOLD: begin
          if (r_cnt == CNT_LAST) begin
            w_state_nxt  = ST_WAIT;
            w_idx_nxt    = '0;
            w_tcnt_nxt   = '0;
            w_rst_nxt[0] = 1'b0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        ST_WAIT: begin
          // A real acknowledge takes priority over a coincident timeout.
          if (rst_ack[r_idx]) begin
            w_advance = 1'b1;
          end else if (r_tcnt == TCNT_LAST) begin
            w_advance  = 1'b1;
            w_terr_nxt = 1'b1;
          end else begin
            w_tcnt_nxt = r_tcnt + TCNT_W'(1);
          end
          if (w_advance) begin
            if (r_idx == IDX_LAST) begin
              w_state_nxt = ST_DONE;
              w_all_nxt   = 1'b1;
            end else begin
              w_idx_nxt  = r_idx + IDX_W'(1);
              w_tcnt_nxt = '0;
              for (int i = 0; i < NUM_OUTS; i++) begin
                if (i == int'(r_idx) + 1) w_rst_nxt[i] = 1'b0;
              end
            end
          end
        end
        ST_DONE: begin
          w_rst_nxt = '0;
        end
        default: begin
          w_state_nxt = ST_RESET;
        end
      endcase
    end
  end

  assign rst_out      = r_rst_out;
  assign all_released = r_all;
  assign timeout_err  = r_terr;

endmodule
